// File: rtl/mmio_fifo_pkg.sv
// rtl/mmio_fifo_pkg.sv - shared register offsets, control bits and status layout
package mmio_fifo_pkg;

    localparam logic [15:0] DATA_OFS   = 16'd0;
    localparam logic [15:0] STATUS_OFS = 16'd2;
    localparam logic [15:0] CTRL_OFS   = 16'd4;

    localparam int FLUSH_BIT = 0;
    localparam int CLR_BIT   = 1;

    // Field order fixes the STATUS bit positions, MSB first.
    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [15:0] depth;
        logic [11:0] rsvd_mid;
        logic        underflow;
        logic        overflow;
        logic        full;
        logic        empty;
        logic [15:0] count;
    } t_fifo_status;

endpackage

// File: rtl/circ_buf.sv
// rtl/circ_buf.sv - circular buffer with registered occupancy and flags
module circ_buf #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;

    // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else
            count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mmio_fifo_port.sv
// rtl/mmio_fifo_port.sv - MMIO window decode onto a 64-bit queue with read responses
module mmio_fifo_port
    import mmio_fifo_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter logic [15:0] BASE_ADDR  = 16'h0020,
    parameter logic [63:0] EMPTY_DATA = 64'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mmio_wr_valid,
    input  logic                   mmio_rd_valid,
    input  logic [15:0]            mmio_addr,
    input  logic [8:0]             mmio_tid,
    input  logic [63:0]            mmio_wr_data,
    output logic                   rsp_valid,
    output logic [8:0]             rsp_tid,
    output logic [63:0]            rsp_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    logic         hit_data, hit_status, hit_ctrl, hit_any;
    logic         rd_op;
    logic         push, pop, flush, clr;
    logic         overflow, underflow;
    logic [63:0]  buf_data;
    logic [63:0]  rd_sel;
    t_fifo_status status;

    assign hit_data   = (mmio_addr == BASE_ADDR + DATA_OFS);
    assign hit_status = (mmio_addr == BASE_ADDR + STATUS_OFS);
    assign hit_ctrl   = (mmio_addr == BASE_ADDR + CTRL_OFS);
    assign hit_any    = hit_data | hit_status | hit_ctrl;

    // A read colliding with a write is dropped entirely.
    assign rd_op = mmio_rd_valid & ~mmio_wr_valid;
    assign push  = mmio_wr_valid & hit_data;
    assign flush = mmio_wr_valid & hit_ctrl & mmio_wr_data[FLUSH_BIT];
    assign clr   = mmio_wr_valid & hit_ctrl & mmio_wr_data[CLR_BIT];
    assign pop   = rd_op & hit_data;

    circ_buf #(.DEPTH(DEPTH), .WIDTH(64)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (mmio_wr_data),
        .pop       (pop),
        .flush     (flush),
        .rd_data   (buf_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push & full)  overflow  <= 1'b1;
            if (pop & empty)  underflow <= 1'b1;
        end
    end

    always_comb begin
        status           = '0;
        status.count     = 16'(count);
        status.empty     = empty;
        status.full      = full;
        status.overflow  = overflow;
        status.underflow = underflow;
        status.depth     = 16'(DEPTH);
    end

    always_comb begin
        rd_sel = '0;
        if (hit_data)
            rd_sel = empty ? EMPTY_DATA : buf_data;
        else if (hit_status)
            rd_sel = status;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rd_op & hit_any;
            if (rd_op & hit_any) begin
                rsp_tid  <= mmio_tid;
                rsp_data <= rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_mmio_fifo_port.sv
// tb/tb_mmio_fifo_port.sv - scoreboard bench for the MMIO queue port
module tb_mmio_fifo_port;
    localparam int          DEPTH  = 8;
    localparam logic [15:0] A_DATA = 16'h0020;
    localparam logic [15:0] A_STAT = 16'h0022;
    localparam logic [15:0] A_CTRL = 16'h0024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mmio_wr_valid = 1'b0;
    logic        mmio_rd_valid = 1'b0;
    logic [15:0] mmio_addr = '0;
    logic [8:0]  mmio_tid = '0;
    logic [63:0] mmio_wr_data = '0;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int errors = 0;
    int checks = 0;

    logic [72:0] sb[$];
    logic [63:0] mq[$];
    bit          m_ovf = 0;
    bit          m_udf = 0;

    mmio_fifo_port #(.DEPTH(DEPTH), .BASE_ADDR(16'h0020), .EMPTY_DATA(64'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .mmio_wr_valid (mmio_wr_valid),
        .mmio_rd_valid (mmio_rd_valid),
        .mmio_addr     (mmio_addr),
        .mmio_tid      (mmio_tid),
        .mmio_wr_data  (mmio_wr_data),
        .rsp_valid     (rsp_valid),
        .rsp_tid       (rsp_tid),
        .rsp_data      (rsp_data),
        .count         (count),
        .full          (full),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_status();
        logic [63:0] s;
        s        = '0;
        s[15:0]  = 16'(mq.size());
        s[16]    = (mq.size() == 0);
        s[17]    = (mq.size() == DEPTH);
        s[18]    = m_ovf;
        s[19]    = m_udf;
        s[47:32] = 16'(DEPTH);
        return s;
    endfunction

    task automatic model_write(input logic [15:0] addr, input logic [63:0] data);
        if (addr == A_DATA) begin
            if (mq.size() < DEPTH) mq.push_back(data);
            else m_ovf = 1;
        end else if (addr == A_CTRL) begin
            if (data[0]) mq.delete();
            if (data[1]) begin
                m_ovf = 0;
                m_udf = 0;
            end
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [63:0] data);
        @(negedge clk);
        mmio_wr_valid = 1'b1;
        mmio_rd_valid = 1'b0;
        mmio_addr     = addr;
        mmio_wr_data  = data;
        model_write(addr, data);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [8:0] tid);
        logic [63:0] e;
        @(negedge clk);
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b1;
        mmio_addr     = addr;
        mmio_tid      = tid;
        if (addr == A_DATA) begin
            if (mq.size() > 0) e = mq.pop_front();
            else begin
                e = 64'h0;
                m_udf = 1;
            end
            sb.push_back({tid, e});
        end else if (addr == A_STAT) begin
            sb.push_back({tid, model_status()});
        end else if (addr == A_CTRL) begin
            sb.push_back({tid, 64'h0});
        end
    endtask

    task automatic wrrd(input logic [15:0] addr, input logic [63:0] data, input logic [8:0] tid);
        @(negedge clk);
        mmio_wr_valid = 1'b1;
        mmio_rd_valid = 1'b1;
        mmio_addr     = addr;
        mmio_tid      = tid;
        mmio_wr_data  = data;
        model_write(addr, data);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mmio_wr_valid = 1'b0;
            mmio_rd_valid = 1'b0;
        end
    endtask

    task automatic check_occ(input string tag);
        check({tag, "_count"}, 64'(count), 64'(mq.size()));
        check({tag, "_empty"}, 64'(empty), 64'(mq.size() == 0));
        check({tag, "_full"},  64'(full),  64'(mq.size() == DEPTH));
    endtask

    always @(negedge clk) begin
        logic [72:0] e;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'h0);
            end else begin
                e = sb.pop_front();
                check("rsp_tid",  64'(rsp_tid), 64'(e[72:64]));
                check("rsp_data", rsp_data, e[63:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_tid",   64'(rsp_tid),   64'h0);
        check("rst_rsp_data",  rsp_data,       64'h0);
        check_occ("rst");

        // Status after reset, including literal layout check
        rd(A_STAT, 9'h05);
        check("status_literal", model_status(), 64'h0000_0008_0001_0000);
        idle(1);

        // Simple push/pop order
        wr(A_DATA, 64'hA1);
        wr(A_DATA, 64'hA2);
        wr(A_DATA, 64'hA3);
        rd(A_DATA, 9'h10);
        rd(A_DATA, 9'h11);
        rd(A_DATA, 9'h12);
        idle(1);
        check_occ("t2");

        // Overflow
        for (int v = 1; v <= DEPTH + 1; v++) wr(A_DATA, 64'(v));
        idle(1);
        check_occ("t3_full");
        rd(A_STAT, 9'h20);
        for (int i = 0; i < DEPTH; i++) rd(A_DATA, 9'(9'h40 + i));
        idle(1);
        check_occ("t3_drain");

        // Underflow and sticky clear
        rd(A_DATA, 9'h1FF);
        rd(A_STAT, 9'h21);
        wr(A_CTRL, 64'h2);
        rd(A_STAT, 9'h22);
        idle(1);

        // Wrap the pointers, then flush
        for (int i = 0; i < 10; i++) begin
            wr(A_DATA, {$urandom, $urandom});
            wr(A_DATA, {$urandom, $urandom});
            rd(A_DATA, 9'(i));
            rd(A_DATA, 9'(i + 100));
        end
        wr(A_DATA, 64'h111);
        wr(A_DATA, 64'h222);
        wr(A_DATA, 64'h333);
        wr(A_CTRL, 64'h1);
        idle(1);
        check_occ("t5_flush");
        rd(A_DATA, 9'h0AA);
        rd(A_STAT, 9'h0AB);
        rd(A_CTRL, 9'h0AC);
        idle(1);

        // Out-of-window read, write to STATUS, collision
        rd(16'h0030, 9'h030);
        wr(A_STAT, 64'hFFFF);
        wrrd(A_DATA, 64'hBEEF, 9'h033);
        idle(1);
        check_occ("t6_collide");
        rd(A_DATA, 9'h034);
        idle(2);

        // Reset during a pending read cancels the response
        @(negedge clk);
        mmio_rd_valid = 1'b1;
        mmio_addr     = A_STAT;
        mmio_tid      = 9'h077;
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_cancel", 64'(rsp_valid), 64'h0);
        mmio_rd_valid = 1'b0;
        rst = 1'b0;
        mq.delete();
        m_ovf = 0;
        m_udf = 0;
        idle(1);
        check("rst_cancel_after", 64'(rsp_valid), 64'h0);
        check_occ("t6_rst");
        rd(A_STAT, 9'h078);
        idle(1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        check("sb_drain", 64'(sb.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
